mc_ctrl: RTL and testbench
==========================

// Module: mc_ctrl
// PURPOSE
//   Multi-cycle control FSM for the MIPS-subset datapath. It sequences FETCH/DECODE/EXE/MEM/WB
//   and drives every datapath select and write enable, including the 2-bit EOp of the immediate
//   extender. It sits between the IR/ALU-zero outputs and the datapath.
//   Instruction and data memories have variable latency and use ready handshakes.
// PARAMETERS
//   CNT_W  32  width of retired-instruction counter instret
// PORTS
//   clk         in   1      rising-edge clock
//   reset       in   1      synchronous, active-low reset (0 = reset)
//   instr       in   32     IR output; valid from DECODE until the end of the instruction
//   zero        in   1      ALU equality flag, sampled in EXE
//   imem_ready  in   1      instruction word valid and IR loadable this cycle
//   dmem_ready  in   1      data access completes this cycle
//   imem_req    out  1      instruction fetch request
//   ir_wr       out  1      IR write enable
//   pc_wr       out  1      PC write enable
//   npc_op      out  2      00 PC+4, 01 branch (PC+ext), 10 j/jal target, 11 jr (rs)
//   eop         out  2      extender op: 00 sign, 01 zero, 10 to-high, 11 sign<<2
//   alu_src_b   out  1      0 rt, 1 ext
//   alu_op      out  2      00 add, 01 sub, 10 or
//   reg_dst     out  2      00 rt, 01 rd, 10 $31
//   reg_wr      out  1      GRF write enable
//   wd_sel      out  2      00 ALU result, 01 DM read data, 10 PC (already old PC+4)
//   dmem_rd     out  1      DM read request
//   dmem_wr     out  1      DM write request
//   state       out  3      current state, for debug
//   instr_done  out  1      1-cycle pulse on the last cycle of each instruction
//   illegal     out  1      1-cycle pulse in DECODE for an unsupported encoding
//   instret     out  CNT_W  retired-instruction count; wraps
// BEHAVIOUR
//   Supported: addu/subu/jr (op 0, funct 21/23/08), ori 0d, lui 0f, addiu 09, lw 23, sw 2b,
//   beq 04, j 02, jal 03. All other encodings are illegal.
//   Reset: when reset=0 at a clock edge, state<=FETCH(0) and instret<=0. While reset=0, all
//   enables and requests are forced to 0 combinationally. Reset takes priority over any
//   pending handshake.
//   States: FETCH=0, DECODE=1, EXE=2, MEM=3, WB=4. Codes 5-7 go to FETCH.
//   Outputs are decoded combinationally from state and instr. Any signal not listed for a
//   state is 0, except eop, which is always decoded from instr:
//     ori -> 01; lui -> 10; beq -> 11; all others -> 00.
//   FETCH: imem_req=1. When imem_ready=1: ir_wr=1, pc_wr=1, npc_op=00, go to DECODE.
//     Otherwise stay in FETCH.
//   DECODE:
//     j   -> pc_wr=1, npc_op=10, done.
//     jal -> same as j, plus reg_wr=1, reg_dst=10, wd_sel=10, all in this single cycle; done.
//     jr  -> pc_wr=1, npc_op=11, done.
//     illegal -> illegal=1, no write enables, done.
//     Else -> EXE.
//   EXE: alu_src_b=1 for I-type; alu_op=01 for subu/beq, 10 for ori, else 00.
//     beq: pc_wr=zero, npc_op=01, done.
//     lw/sw -> MEM. Others -> WB.
//   MEM: lw holds dmem_rd=1 and sw holds dmem_wr=1 (with alu_src_b=1) until dmem_ready=1.
//     On ready: sw is done; lw goes to WB.
//   WB: reg_wr=1.
//     R-type: reg_dst=01, wd_sel=00. ori/lui/addiu: reg_dst=00, wd_sel=00.
//     lw: reg_dst=00, wd_sel=01. Done.
//   "Done" means: instr_done=1 this cycle, next state is FETCH, and instret increments at the
//   same edge (wraps from all-ones to 0). Illegal instructions also count.
//   Latency with ready=1 each cycle: j/jal/jr/illegal 2 cycles, beq 3, ALU ops 4, sw 4, lw 5.
//   Each wait cycle adds one.
// TESTING
//   reset=0 for 3 cycles -> state=0, all enables 0, instret=0; release with imem_ready=1 ->
//     ir_wr=pc_wr=1 on the first cycle.
//   ori 0x34018000 -> DECODE, EXE(eop=01, alu_src_b=1, alu_op=10), WB(reg_wr=1, reg_dst=00);
//     4 cycles; instret=1.
//   lw 0x8C220004 with dmem_ready low 3 cycles -> dmem_rd=1 for 4 MEM cycles, WB wd_sel=01;
//     8 cycles total.
//   beq 0x10220003: zero=1 in EXE -> eop=11, alu_op=01, pc_wr=1, npc_op=01;
//     zero=0 -> pc_wr=0; 3 cycles each.
//   jal 0x0C000010 -> DECODE cycle has pc_wr=1, npc_op=10, reg_wr=1, reg_dst=10, wd_sel=10,
//     instr_done=1.
//   op 0x3F -> illegal=1 for 1 cycle, no writes, instret++.
//   reset=0 during MEM wait -> next cycle state=0, dmem_rd=0.

Source files
------------

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multi-cycle control FSM for the MIPS-subset datapath
module mc_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instr,
    input  logic             zero,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             ir_wr,
    output logic             pc_wr,
    output logic [1:0]       npc_op,
    output logic [1:0]       eop,
    output logic             alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       reg_dst,
    output logic             reg_wr,
    output logic [1:0]       wd_sel,
    output logic             dmem_rd,
    output logic             dmem_wr,
    output logic [2:0]       state,
    output logic             instr_done,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXE    = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             done;

    logic [5:0] op;
    logic [5:0] funct;
    logic is_addu, is_subu, is_jr, is_ori, is_lui, is_addiu;
    logic is_lw, is_sw, is_beq, is_j, is_jal, is_r, is_illegal, uses_imm;

    assign op    = instr[31:26];
    assign funct = instr[5:0];

    assign is_addu  = (op == 6'h00) && (funct == 6'h21);
    assign is_subu  = (op == 6'h00) && (funct == 6'h23);
    assign is_jr    = (op == 6'h00) && (funct == 6'h08);
    assign is_ori   = (op == 6'h0d);
    assign is_lui   = (op == 6'h0f);
    assign is_addiu = (op == 6'h09);
    assign is_lw    = (op == 6'h23);
    assign is_sw    = (op == 6'h2b);
    assign is_beq   = (op == 6'h04);
    assign is_j     = (op == 6'h02);
    assign is_jal   = (op == 6'h03);
    assign is_r     = is_addu | is_subu;
    // beq compares two registers, so it is not counted as an immediate-operand instruction here
    assign uses_imm = is_ori | is_lui | is_addiu | is_lw | is_sw;
    assign is_illegal = ~(is_r | is_jr | is_ori | is_lui | is_addiu | is_lw | is_sw |
                          is_beq | is_j | is_jal);

    // Extender op follows the instruction alone, independent of state and reset
    assign eop = is_ori ? 2'b01 : (is_lui ? 2'b10 : (is_beq ? 2'b11 : 2'b00));

    assign state   = state_q;
    assign instret = instret_q;

    // Next-state, datapath controls and retire count; reset masks every control output
    always_comb begin
        state_d    = state_q;
        done       = 1'b0;
        imem_req   = 1'b0;
        ir_wr      = 1'b0;
        pc_wr      = 1'b0;
        npc_op     = 2'b00;
        alu_src_b  = 1'b0;
        alu_op     = 2'b00;
        reg_dst    = 2'b00;
        reg_wr     = 1'b0;
        wd_sel     = 2'b00;
        dmem_rd    = 1'b0;
        dmem_wr    = 1'b0;
        illegal    = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_wr   = 1'b1;
                    pc_wr   = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_j || is_jal) begin
                    pc_wr  = 1'b1;
                    npc_op = 2'b10;
                    done   = 1'b1;
                    if (is_jal) begin
                        reg_wr  = 1'b1;
                        reg_dst = 2'b10;
                        wd_sel  = 2'b10;
                    end
                end else if (is_jr) begin
                    pc_wr  = 1'b1;
                    npc_op = 2'b11;
                    done   = 1'b1;
                end else if (is_illegal) begin
                    illegal = 1'b1;
                    done    = 1'b1;
                end else begin
                    state_d = S_EXE;
                end
            end
            S_EXE: begin
                alu_src_b = uses_imm;
                alu_op    = (is_subu || is_beq) ? 2'b01 : (is_ori ? 2'b10 : 2'b00);
                if (is_beq) begin
                    pc_wr  = zero;
                    npc_op = 2'b01;
                    done   = 1'b1;
                end else if (is_lw || is_sw) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                // Address operand stays selected for the whole variable-latency access
                alu_src_b = 1'b1;
                dmem_rd   = is_lw;
                dmem_wr   = is_sw;
                if (dmem_ready) begin
                    if (is_sw) begin
                        done = 1'b1;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                reg_wr  = 1'b1;
                reg_dst = is_r ? 2'b01 : 2'b00;
                wd_sel  = is_lw ? 2'b01 : 2'b00;
                done    = 1'b1;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
        if (done) begin
            state_d = S_FETCH;
        end
        instret_d  = done ? instret_q + {{(CNT_W-1){1'b0}}, 1'b1} : instret_q;
        instr_done = done;
        if (!reset) begin
            imem_req   = 1'b0;
            ir_wr      = 1'b0;
            pc_wr      = 1'b0;
            npc_op     = 2'b00;
            alu_src_b  = 1'b0;
            alu_op     = 2'b00;
            reg_dst    = 2'b00;
            reg_wr     = 1'b0;
            wd_sel     = 2'b00;
            dmem_rd    = 1'b0;
            dmem_wr    = 1'b0;
            illegal    = 1'b0;
            instr_done = 1'b0;
        end
    end

    // State and retire-counter registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - self-checking bench for mc_ctrl
module tb_mc_ctrl;

    localparam int C_ADDU = 0, C_SUBU = 1, C_JR = 2, C_ORI = 3, C_LUI = 4, C_ADDIU = 5;
    localparam int C_LW = 6, C_SW = 7, C_BEQ = 8, C_J = 9, C_JAL = 10, C_ILL = 11;

    typedef struct packed {
        logic [2:0] st;
        logic       imem_req;
        logic       ir_wr;
        logic       pc_wr;
        logic [1:0] npc_op;
        logic [1:0] eop;
        logic       alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] reg_dst;
        logic       reg_wr;
        logic [1:0] wd_sel;
        logic       dmem_rd;
        logic       dmem_wr;
        logic       instr_done;
        logic       illegal;
        logic [3:0] cnt;
    } ctl_t;

    typedef struct {
        ctl_t        c;
        logic [31:0] ins;
        logic        ir;
        logic        dr;
        logic        z;
    } step_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] instr;
    logic        zero, imem_ready, dmem_ready;
    logic        imem_req, ir_wr, pc_wr, alu_src_b, reg_wr, dmem_rd, dmem_wr;
    logic        instr_done, illegal;
    logic [1:0]  npc_op, eop, alu_op, reg_dst, wd_sel;
    logic [2:0]  state;
    logic [3:0]  instret;

    int          checks = 0;
    int          errors = 0;
    int          cnt_m = 0;
    logic [31:0] cur_ins = 32'h0;
    step_t       q[$];

    always #5 clk = ~clk;

    mc_ctrl #(.CNT_W(4)) dut (
        .clk(clk), .reset(reset_n), .instr(instr), .zero(zero),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .ir_wr(ir_wr), .pc_wr(pc_wr), .npc_op(npc_op),
        .eop(eop), .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_dst(reg_dst),
        .reg_wr(reg_wr), .wd_sel(wd_sel), .dmem_rd(dmem_rd), .dmem_wr(dmem_wr),
        .state(state), .instr_done(instr_done), .illegal(illegal), .instret(instret)
    );

    function automatic int cls_of(input logic [31:0] w);
        case (w[31:26])
            6'h00: begin
                if (w[5:0] == 6'h21) return C_ADDU;
                if (w[5:0] == 6'h23) return C_SUBU;
                if (w[5:0] == 6'h08) return C_JR;
                return C_ILL;
            end
            6'h0d: return C_ORI;
            6'h0f: return C_LUI;
            6'h09: return C_ADDIU;
            6'h23: return C_LW;
            6'h2b: return C_SW;
            6'h04: return C_BEQ;
            6'h02: return C_J;
            6'h03: return C_JAL;
            default: return C_ILL;
        endcase
    endfunction

    function automatic logic [1:0] eop_of(input logic [31:0] w);
        int c;
        c = cls_of(w);
        if (c == C_ORI) return 2'b01;
        if (c == C_LUI) return 2'b10;
        if (c == C_BEQ) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic ctl_t sample();
        ctl_t a;
        a.st = state; a.imem_req = imem_req; a.ir_wr = ir_wr; a.pc_wr = pc_wr;
        a.npc_op = npc_op; a.eop = eop; a.alu_src_b = alu_src_b; a.alu_op = alu_op;
        a.reg_dst = reg_dst; a.reg_wr = reg_wr; a.wd_sel = wd_sel; a.dmem_rd = dmem_rd;
        a.dmem_wr = dmem_wr; a.instr_done = instr_done; a.illegal = illegal; a.cnt = instret;
        return a;
    endfunction

    task automatic check(input ctl_t e, input string tag);
        ctl_t a;
        a = sample();
        checks++;
        assert (a === e) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, a, e);
        end
    endtask

    // One expected cycle: the retire count seen is the one before this cycle's retirement
    task automatic push(input ctl_t c, input logic [31:0] ins, input logic ir, input logic dr,
                        input logic z);
        step_t s;
        c.eop = eop_of(ins);
        c.cnt = cnt_m[3:0];
        s.c = c; s.ins = ins; s.ir = ir; s.dr = dr; s.z = z;
        q.push_back(s);
        if (c.instr_done) cnt_m = (cnt_m + 1) % 16;
    endtask

    // Builds the cycle-by-cycle trace an instruction should produce from its class
    task automatic gen(input logic [31:0] w, input int iw, input int dw, input logic z);
        int   c;
        ctl_t e;
        c = cls_of(w);
        for (int k = 0; k <= iw; k++) begin
            e = '0; e.imem_req = 1'b1;
            if (k == iw) begin e.ir_wr = 1'b1; e.pc_wr = 1'b1; end
            push(e, cur_ins, k == iw, rb(), rb());
        end
        cur_ins = w;
        e = '0; e.st = 3'd1;
        if (c == C_J || c == C_JAL || c == C_JR) begin
            e.pc_wr = 1'b1; e.instr_done = 1'b1;
            e.npc_op = (c == C_JR) ? 2'b11 : 2'b10;
            if (c == C_JAL) begin e.reg_wr = 1'b1; e.reg_dst = 2'b10; e.wd_sel = 2'b10; end
        end else if (c == C_ILL) begin
            e.illegal = 1'b1; e.instr_done = 1'b1;
        end
        push(e, w, rb(), rb(), rb());
        if (e.instr_done) return;
        e = '0; e.st = 3'd2;
        e.alu_src_b = (c == C_ORI || c == C_LUI || c == C_ADDIU || c == C_LW || c == C_SW);
        e.alu_op = (c == C_SUBU || c == C_BEQ) ? 2'b01 : ((c == C_ORI) ? 2'b10 : 2'b00);
        if (c == C_BEQ) begin
            e.pc_wr = z; e.npc_op = 2'b01; e.instr_done = 1'b1;
            push(e, w, rb(), rb(), z);
            return;
        end
        push(e, w, rb(), rb(), rb());
        if (c == C_LW || c == C_SW) begin
            for (int k = 0; k <= dw; k++) begin
                e = '0; e.st = 3'd3; e.alu_src_b = 1'b1;
                e.dmem_rd = (c == C_LW); e.dmem_wr = (c == C_SW);
                e.instr_done = (c == C_SW) && (k == dw);
                push(e, w, rb(), k == dw, rb());
            end
            if (c == C_SW) return;
        end
        e = '0; e.st = 3'd4; e.reg_wr = 1'b1; e.instr_done = 1'b1;
        e.reg_dst = (c == C_ADDU || c == C_SUBU) ? 2'b01 : 2'b00;
        e.wd_sel = (c == C_LW) ? 2'b01 : 2'b00;
        push(e, w, rb(), rb(), rb());
    endtask

    task automatic drive_and_check(input step_t s, input string tag);
        @(negedge clk);
        reset_n = 1'b1; instr = s.ins; imem_ready = s.ir; dmem_ready = s.dr; zero = s.z;
        #1;
        check(s.c, tag);
    endtask

    task automatic run(input logic [31:0] w, input int iw, input int dw, input logic z);
        step_t s;
        int    n;
        gen(w, iw, dw, z);
        n = 0;
        while (q.size() > 0) begin
            s = q.pop_front();
            drive_and_check(s, $sformatf("ins=%h cyc=%0d", w, n));
            n++;
        end
    endtask

    initial begin
        step_t       s;
        ctl_t        e;
        logic [31:0] r, w;
        int          k;

        reset_n = 1'b0; instr = 32'h0; zero = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            e = '0;
            check(e, $sformatf("reset cyc=%0d", i));
        end

        run(32'h34018000, 0, 0, 1'b0);
        run(32'h8C220004, 0, 3, 1'b0);
        run(32'h10220003, 0, 0, 1'b1);
        run(32'h10220003, 0, 0, 1'b0);
        run(32'h0C000010, 0, 0, 1'b0);
        run(32'hFC000000, 0, 0, 1'b0);
        run(32'h03E00008, 2, 0, 1'b0);
        run(32'hAC220008, 1, 2, 1'b0);
        run(32'h08000004, 1, 0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            r = $urandom;
            k = $urandom_range(0, 11);
            case (k)
                0:  w = {6'h00, r[25:6], 6'h21};
                1:  w = {6'h00, r[25:6], 6'h23};
                2:  w = {6'h00, r[25:6], 6'h08};
                3:  w = {6'h0d, r[25:0]};
                4:  w = {6'h0f, r[25:0]};
                5:  w = {6'h09, r[25:0]};
                6:  w = {6'h23, r[25:0]};
                7:  w = {6'h2b, r[25:0]};
                8:  w = {6'h04, r[25:0]};
                9:  w = {6'h02, r[25:0]};
                10: w = {6'h03, r[25:0]};
                default: w = r;
            endcase
            run(w, $urandom_range(0, 2), $urandom_range(0, 3), rb());
        end

        // Reset asserted while a load is waiting for data memory
        gen(32'h8C220004, 0, 5, 1'b0);
        for (int i = 0; i < 4; i++) begin
            s = q.pop_front();
            drive_and_check(s, $sformatf("pre-abort cyc=%0d", i));
        end
        s = q.pop_front();
        @(negedge clk);
        reset_n = 1'b0; instr = s.ins; imem_ready = 1'b1; dmem_ready = 1'b0; zero = 1'b0;
        #1;
        e = '0; e.st = 3'd3; e.eop = s.c.eop; e.cnt = s.c.cnt;
        check(e, "abort in MEM");
        q.delete();
        cnt_m = 0;
        cur_ins = 32'h8C220004;
        @(negedge clk);
        reset_n = 1'b1; imem_ready = 1'b0;
        #1;
        e = '0; e.imem_req = 1'b1;
        check(e, "after abort");
        run(32'h00221821, 0, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
